// File: rtl/updown_counter_if.sv
// Command/status bundle between the front-panel switch path and the up/down counter core.
// Commands are level signals from debouncers; the core acts on their rising edges.
interface updown_counter_if #(
    parameter int WIDTH = 16
);
    logic             i_up;
    logic             i_down;
    logic             i_startstop;
    logic             i_load;
    logic [WIDTH-1:0] i_load_val;
    logic [WIDTH-1:0] i_max;
    logic [WIDTH-1:0] o_count;
    logic             o_dir;
    logic             o_running;
    logic             o_tick;
    logic             o_tc;

    modport master (
        output i_up, i_down, i_startstop, i_load, i_load_val, i_max,
        input  o_count, o_dir, o_running, o_tick, o_tc
    );

    modport slave (
        input  i_up, i_down, i_startstop, i_load, i_load_val, i_max,
        output o_count, o_dir, o_running, o_tick, o_tc
    );
endinterface

// File: rtl/updown_counter_core.sv
// Up/down counter stepped by an internal prescaler tick on the system clock, with
// edge-detected commands, RUN/STOP control, parallel load and wrap/saturate limits.
module updown_counter_core #(
    parameter int WIDTH     = 16,
    parameter int DIVIDER   = 3_125_000,
    parameter int DIV_WIDTH = 24,
    parameter bit SATURATE  = 1'b0,
    parameter bit RESET_DIR = 1'b1
) (
    input logic              clk,
    input logic              reset,
    updown_counter_if.slave  bus
);
    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(DIVIDER - 1);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic                 dir_q, dir_d;
    logic [DIV_WIDTH-1:0] presc_q, presc_d;
    logic                 tick_q, tick_d;
    logic                 tc_q, tc_d;
    logic                 up_q, down_q, ss_q, load_q;

    logic up_edge, down_edge, ss_edge, load_edge;
    logic step, auto_stop;

    assign up_edge   = bus.i_up        & ~up_q;
    assign down_edge = bus.i_down      & ~down_q;
    assign ss_edge   = bus.i_startstop & ~ss_q;
    assign load_edge = bus.i_load      & ~load_q;
    assign step      = (state_q == ST_RUN) && (presc_q == DIV_LAST);

    always_ff @(posedge clk) begin
        // Edge history tracks the input level even in reset, so a held input gives no edge.
        up_q   <= bus.i_up;
        down_q <= bus.i_down;
        ss_q   <= bus.i_startstop;
        load_q <= bus.i_load;
        if (reset) begin
            state_q <= ST_STOP;
            count_q <= '0;
            dir_q   <= RESET_DIR;
            presc_q <= '0;
            tick_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            tc_q    <= tc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        dir_d     = dir_q;
        presc_d   = '0;
        tick_d    = 1'b0;
        tc_d      = 1'b0;
        auto_stop = 1'b0;

        if (state_q == ST_RUN) begin
            presc_d = step ? '0 : presc_q + DIV_WIDTH'(1);
        end

        // A load wins over a coincident step: the step is dropped entirely.
        if (load_edge) begin
            count_d = bus.i_load_val;
            presc_d = '0;
        end else if (step) begin
            tick_d = 1'b1;
            if (dir_q) begin
                if (count_q >= bus.i_max) begin
                    tc_d      = 1'b1;
                    count_d   = SATURATE ? bus.i_max : '0;
                    auto_stop = SATURATE;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q > bus.i_max) begin
                    count_d = bus.i_max;
                end else if (count_q == '0) begin
                    tc_d      = 1'b1;
                    count_d   = SATURATE ? '0 : bus.i_max;
                    auto_stop = SATURATE;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end

        if (up_edge && !down_edge) begin
            dir_d = 1'b1;
        end else if (down_edge && !up_edge) begin
            dir_d = 1'b0;
        end

        if (auto_stop) begin
            state_d = ST_STOP;
        end else if (ss_edge) begin
            state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
        end

        if (state_d == ST_STOP) begin
            presc_d = '0;
        end
    end

    assign bus.o_count   = count_q;
    assign bus.o_dir     = dir_q;
    assign bus.o_running = (state_q == ST_RUN);
    assign bus.o_tick    = tick_q;
    assign bus.o_tc      = tc_q;
endmodule

// File: tb/tb_updown_counter_core.sv
// Randomised bench for updown_counter_core: a wrap instance and a saturate instance
// share one stimulus stream and are scored against a cycle-level reference model.
module tb_updown_counter_core;
  localparam int W   = 4;
  localparam int DIV = 4;

  typedef struct {
    int cnt;
    bit dir;
    bit run;
    int presc;
    bit p_up, p_dn, p_ss, p_ld;
    bit tick, tc;
  } mstate_t;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  int cycle = 0;

  updown_counter_if #(.WIDTH(W)) bus0 ();
  updown_counter_if #(.WIDTH(W)) bus1 ();

  assign bus1.i_up        = bus0.i_up;
  assign bus1.i_down      = bus0.i_down;
  assign bus1.i_startstop = bus0.i_startstop;
  assign bus1.i_load      = bus0.i_load;
  assign bus1.i_load_val  = bus0.i_load_val;
  assign bus1.i_max       = bus0.i_max;

  updown_counter_core #(.WIDTH(W), .DIVIDER(DIV), .DIV_WIDTH(3), .SATURATE(1'b0), .RESET_DIR(1'b1))
    dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  updown_counter_core #(.WIDTH(W), .DIVIDER(DIV), .DIV_WIDTH(3), .SATURATE(1'b1), .RESET_DIR(1'b0))
    dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // reference model
  mstate_t m0, m1;
  logic [W+3:0] exp_q0[$];
  logic [W+3:0] exp_q1[$];

  function automatic mstate_t model_next(input mstate_t s, input bit rst, input bit up,
                                         input bit dn, input bit ss, input bit ld,
                                         input int lval, input int mx, input bit sat,
                                         input bit rdir);
    mstate_t n;
    bit e_up, e_dn, e_ss, e_ld, stepping, halt;
    n = s;
    n.tick = 0;
    n.tc = 0;
    n.p_up = up; n.p_dn = dn; n.p_ss = ss; n.p_ld = ld;
    if (rst) begin
      n.cnt = 0; n.dir = rdir; n.run = 0; n.presc = 0;
      return n;
    end
    e_up = up && !s.p_up;
    e_dn = dn && !s.p_dn;
    e_ss = ss && !s.p_ss;
    e_ld = ld && !s.p_ld;
    stepping = s.run && (s.presc == DIV - 1);
    halt = 0;
    n.presc = s.run ? (s.presc + 1) % DIV : 0;
    if (e_ld) begin
      n.cnt = lval;
      n.presc = 0;
    end else if (stepping) begin
      n.tick = 1;
      if (s.dir) begin
        if (s.cnt < mx) n.cnt = s.cnt + 1;
        else begin
          n.tc = 1;
          n.cnt = sat ? mx : 0;
          halt = sat;
        end
      end else begin
        if (s.cnt > mx) n.cnt = mx;
        else if (s.cnt > 0) n.cnt = s.cnt - 1;
        else begin
          n.tc = 1;
          n.cnt = sat ? 0 : mx;
          halt = sat;
        end
      end
    end
    if (e_up != e_dn) n.dir = e_up;
    if (halt) n.run = 0;
    else if (e_ss) n.run = !s.run;
    if (!n.run) n.presc = 0;
    return n;
  endfunction

  function automatic logic [W+3:0] pack(input mstate_t s);
    logic [W-1:0] c;
    c = W'(s.cnt);
    return {c, s.dir, s.run, s.tick, s.tc};
  endfunction

  always @(posedge clk) begin
    m0 = model_next(m0, reset, bus0.i_up, bus0.i_down, bus0.i_startstop, bus0.i_load,
                    int'(bus0.i_load_val), int'(bus0.i_max), 1'b0, 1'b1);
    m1 = model_next(m1, reset, bus0.i_up, bus0.i_down, bus0.i_startstop, bus0.i_load,
                    int'(bus0.i_load_val), int'(bus0.i_max), 1'b1, 1'b0);
    exp_q0.push_back(pack(m0));
    exp_q1.push_back(pack(m1));
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W+3:0] e, a;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      a = {bus0.o_count, bus0.o_dir, bus0.o_running, bus0.o_tick, bus0.o_tc};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL wrap_dut cycle %0d: got cnt/dir/run/tick/tc=%h/%b/%b/%b/%b want %h/%b/%b/%b/%b",
                 cycle, a[W+3:4], a[3], a[2], a[1], a[0], e[W+3:4], e[3], e[2], e[1], e[0]);
      end
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      a = {bus1.o_count, bus1.o_dir, bus1.o_running, bus1.o_tick, bus1.o_tc};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL sat_dut cycle %0d: got cnt/dir/run/tick/tc=%h/%b/%b/%b/%b want %h/%b/%b/%b/%b",
                 cycle, a[W+3:4], a[3], a[2], a[1], a[0], e[W+3:4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_ss();
    bus0.i_startstop = 1'b1;
    wait_cycles(2);
    bus0.i_startstop = 1'b0;
    wait_cycles(1);
  endtask

  task automatic press_up();
    bus0.i_up = 1'b1;
    wait_cycles(2);
    bus0.i_up = 1'b0;
    wait_cycles(1);
  endtask

  task automatic press_down();
    bus0.i_down = 1'b1;
    wait_cycles(2);
    bus0.i_down = 1'b0;
    wait_cycles(1);
  endtask

  task automatic wait_count(input int want, input int budget, input string what);
    int n;
    n = 0;
    while (m0.cnt != want && n < budget) begin
      wait_cycles(1);
      n++;
    end
    checks++;
    if (m0.cnt != want) begin
      failures++;
      $display("FAIL %s: count %0d not reached within %0d cycles (model at %0d)", what, want, budget, m0.cnt);
    end
  endtask

  task automatic wait_tick_cycle(input int budget);
    int n;
    n = 0;
    while (!(m0.run && m0.presc == DIV - 1) && n < budget) begin
      wait_cycles(1);
      n++;
    end
    checks++;
    if (!(m0.run && m0.presc == DIV - 1)) begin
      failures++;
      $display("FAIL load_on_tick: no step cycle within %0d cycles (run=%b presc=%0d)", budget, m0.run, m0.presc);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus0.i_up = 1'b0;
    bus0.i_down = 1'b0;
    bus0.i_startstop = 1'b0;
    bus0.i_load = 1'b0;
    bus0.i_load_val = '0;
    bus0.i_max = 4'd5;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(2);

    // count up 0..5 and wrap
    press_ss();
    wait_cycles(30);

    // down from 0 wraps to max, then max lowered below count
    wait_count(0, 60, "reach_zero");
    press_down();
    wait_count(5, 60, "down_wrap_to_max");
    bus0.i_max = 4'd2;
    wait_cycles(10);
    bus0.i_max = 4'd5;

    // load on a step cycle, then up from above max
    press_up();
    wait_tick_cycle(20);
    bus0.i_load_val = 4'd9;
    bus0.i_load = 1'b1;
    wait_cycles(2);
    bus0.i_load = 1'b0;
    wait_cycles(12);

    // max of zero pins the count
    bus0.i_max = 4'd0;
    wait_cycles(16);
    bus0.i_max = 4'd3;
    wait_cycles(24);

    // simultaneous direction edges
    bus0.i_up = 1'b1;
    bus0.i_down = 1'b1;
    wait_cycles(2);
    bus0.i_up = 1'b0;
    bus0.i_down = 1'b0;
    wait_cycles(2);

    // startstop held through reset
    bus0.i_startstop = 1'b1;
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(5);
    bus0.i_startstop = 1'b0;
    wait_cycles(2);

    // reset in mid-run at count 3
    bus0.i_max = 4'd5;
    press_ss();
    wait_count(3, 40, "reach_three");
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    wait_cycles(3);

    // randomised phase
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) bus0.i_up = ~bus0.i_up;
      if ($urandom_range(0, 29) == 0) bus0.i_down = ~bus0.i_down;
      if ($urandom_range(0, 24) == 0) bus0.i_startstop = ~bus0.i_startstop;
      if ($urandom_range(0, 39) == 0) bus0.i_load = ~bus0.i_load;
      if ($urandom_range(0, 7) == 0) bus0.i_load_val = W'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) bus0.i_max = W'($urandom_range(0, 15));
      reset = ($urandom_range(0, 599) == 0);
      wait_cycles(1);
    end
    reset = 1'b0;
    wait_cycles(3);
    #1;

    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: %0d/%0d entries left, want 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
